ts_cc_monitor: RTL and testbench

Parametrised N-channel MPEG-2 TS continuity-counter monitor: the successor to the fixed 4-channel, 8-bit packet-loss counter. It sits on the per-channel byte streams after sync detection. Each channel parses the 4-byte TS header, filters on a programmable PID and checks the 4-bit continuity_counter (CC). The CC rules cover duplicate-packet tolerance and adaptation-only packets. Outputs are saturating per-channel error counts, per-channel error pulses and a registered aggregate total.

---
 rtl/ts_cc_monitor.sv | 149 ++++++++++++++
 tb/tb_ts_cc_monitor.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ts_cc_monitor.sv
// ts_cc_monitor: N-channel MPEG-2 TS continuity-counter monitor.
// Parses each channel's TS header and counts CC discontinuities.
module ts_cc_monitor #(
   parameter int N_CH  = 4,
   parameter int CNT_W = 8,
   parameter int TOT_W = CNT_W + $clog2(N_CH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_CH-1:0]       valid,
   input  logic [N_CH-1:0]       sync,
   input  logic [N_CH*8-1:0]     data,
   input  logic [N_CH*13-1:0]    pid_filter,
   input  logic                  en_reset_counter,
   output logic [N_CH*CNT_W-1:0] error_count,
   output logic [N_CH-1:0]       error_pulse,
   output logic [TOT_W-1:0]      total_errors
);

   logic [TOT_W-1:0] sum;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [7:0]       d;
      logic [12:0]      pid;
      logic [12:0]      pid_q;
      logic [2:0]       idx;
      logic [7:0]       b0;
      logic             tei;
      logic [4:0]       pid_hi;
      logic [7:0]       pid_lo;
      logic [3:0]       cc;
      logic [3:0]       cc_inc;
      logic [3:0]       last_cc;
      logic [3:0]       nxt_cc;
      logic [1:0]       afc;
      logic             locked;
      logic             nxt_locked;
      logic             dup_seen;
      logic             nxt_dup;
      logic             hdr_ok;
      logic             eval;
      logic             err;
      logic             pulse_q;
      logic [CNT_W-1:0] cnt_q;

      assign d      = data[8*i +: 8];
      assign pid    = pid_filter[13*i +: 13];
      assign cc     = d[3:0];
      assign afc    = d[5:4];
      assign cc_inc = last_cc + 4'd1;

      // Header capture; idx is the next byte expected, 4 = parked
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            idx    <= 3'd4;
            b0     <= '0;
            tei    <= 1'b0;
            pid_hi <= '0;
            pid_lo <= '0;
         end else if (valid[i]) begin
            if (sync[i]) begin
               b0  <= d;
               idx <= 3'd1;
            end else if (idx < 3'd4) begin
               if (idx == 3'd1) begin
                  tei    <= d[7];
                  pid_hi <= d[4:0];
               end
               if (idx == 3'd2) pid_lo <= d;
               idx <= idx + 3'd1;
            end
         end
      end

      // CC rule evaluation when byte 3 arrives
      always_comb begin
         hdr_ok = (b0 == 8'h47) && !tei &&
                  ({pid_hi, pid_lo} == pid) &&
                  (afc != 2'b00);
         eval   = valid[i] && !sync[i] &&
                  (idx == 3'd3) && hdr_ok;
         err        = 1'b0;
         nxt_cc     = last_cc;
         nxt_locked = locked;
         nxt_dup    = dup_seen;
         if (eval) begin
            if (!locked) begin
               nxt_cc     = cc;
               nxt_locked = 1'b1;
               nxt_dup    = 1'b0;
            end else if (afc[0]) begin
               if (cc == cc_inc) begin
                  nxt_cc  = cc;
                  nxt_dup = 1'b0;
               end else if (cc == last_cc && !dup_seen) begin
                  nxt_dup = 1'b1;
               end else begin
                  err     = 1'b1;
                  nxt_cc  = cc;
                  nxt_dup = 1'b0;
               end
            end else if (cc != last_cc) begin
               err     = 1'b1;
               nxt_cc  = cc;
               nxt_dup = 1'b0;
            end
         end
      end

      // Channel state, error pulse and saturating counter
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            pid_q    <= '0;
            last_cc  <= '0;
            locked   <= 1'b0;
            dup_seen <= 1'b0;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
         end else begin
            pid_q    <= pid;
            last_cc  <= nxt_cc;
            dup_seen <= nxt_dup;
            locked   <= nxt_locked && (pid == pid_q);
            pulse_q  <= err;
            if (en_reset_counter)
               cnt_q <= '0;
            else if (pulse_q && cnt_q != {CNT_W{1'b1}})
               cnt_q <= cnt_q + CNT_W'(1);
         end
      end

      assign error_count[CNT_W*i +: CNT_W] = cnt_q;
      assign error_pulse[i] = pulse_q;
   end

   // Zero-extended sum of every channel counter
   always_comb begin
      sum = '0;
      for (int k = 0; k < N_CH; k++)
         sum = sum + TOT_W'(error_count[CNT_W*k +: CNT_W]);
   end

   // Registered aggregate
   always_ff @(posedge clk or posedge reset) begin
      if (reset) total_errors <= '0;
      else       total_errors <= sum;
   end

endmodule

// File: tb/tb_ts_cc_monitor.sv
// tb_ts_cc_monitor: directed bench for ts_cc_monitor.
// Packets are driven between negedges; outputs checked at negedges.
module tb_ts_cc_monitor;

   logic        clk;
   logic        reset;
   logic [3:0]  valid;
   logic [3:0]  sync;
   logic [31:0] data;
   logic [51:0] pid_filter;
   logic        en_reset_counter;
   logic [31:0] error_count;
   logic [3:0]  error_pulse;
   logic [9:0]  total_errors;

   int vectors;
   int miscompares;
   int npulse;

   ts_cc_monitor #(.N_CH(4), .CNT_W(8)) dut (
      .clk              (clk),
      .reset            (reset),
      .valid            (valid),
      .sync             (sync),
      .data             (data),
      .pid_filter       (pid_filter),
      .en_reset_counter (en_reset_counter),
      .error_count      (error_count),
      .error_pulse      (error_pulse),
      .total_errors     (total_errors)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_raw(input logic [3:0] m, input logic [12:0] pid,
                           input logic [1:0] afc, input logic [3:0] cc,
                           input logic tei, input logic [7:0] sb);
      logic [7:0] b [4];
      b[0] = sb;
      b[1] = {tei, 2'b00, pid[12:8]};
      b[2] = pid[7:0];
      b[3] = {2'b00, afc, cc};
      for (int k = 0; k < 4; k++) begin
         valid = m;
         sync  = (k == 0) ? m : 4'b0000;
         for (int c = 0; c < 4; c++) data[8*c +: 8] = b[k];
         @(negedge clk);
      end
      valid = '0;
      sync  = '0;
   endtask

   task automatic pkt(input logic [3:0] m, input logic [3:0] cc);
      send_raw(m, 13'h100, 2'b01, cc, 1'b0, 8'h47);
   endtask

   task automatic pkt_afc(input logic [3:0] m, input logic [1:0] afc,
                          input logic [3:0] cc);
      send_raw(m, 13'h100, afc, cc, 1'b0, 8'h47);
   endtask

   initial begin
      vectors          = 0;
      miscompares      = 0;
      npulse           = 0;
      reset            = 1'b1;
      valid            = '0;
      sync             = '0;
      data             = '0;
      en_reset_counter = 1'b0;
      pid_filter       = {4{13'h100}};
      repeat (2) @(negedge clk);
      chk("rst_count", error_count, 0);
      chk("rst_pulse", error_pulse, 0);
      chk("rst_total", total_errors, 0);
      reset = 1'b0;
      @(negedge clk);

      // lock and in-order sequence with wrap on ch0
      for (int k = 0; k < 13; k++) begin
         pkt(4'b0001, 4'((5 + k) % 16));
         chk("seq_pulse", error_pulse, 0);
      end
      repeat (2) @(negedge clk);
      chk("seq_count", error_count, 0);

      // discontinuity on ch1
      pkt(4'b0010, 4'd3);
      pkt(4'b0010, 4'd4);
      pkt(4'b0010, 4'd9);
      chk("disc_pulse", error_pulse, 4'b0010);
      @(negedge clk);
      chk("disc_pulse_end", error_pulse, 0);
      chk("disc_count", error_count, 32'h0000_0100);
      @(negedge clk);
      chk("disc_total", total_errors, 1);
      pkt(4'b0010, 4'd10);
      chk("disc_resync", error_pulse, 0);

      // duplicates on ch0 (last_cc = 1)
      pkt(4'b0001, 4'd2);
      pkt(4'b0001, 4'd2);
      chk("dup_ok", error_pulse, 0);
      pkt(4'b0001, 4'd2);
      chk("dup_third", error_pulse, 4'b0001);
      for (int k = 3; k < 8; k++) pkt(4'b0001, 4'(k));
      pkt_afc(4'b0001, 2'b10, 4'd7);
      chk("afc10_same", error_pulse, 0);
      pkt_afc(4'b0001, 2'b10, 4'd8);
      chk("afc10_diff", error_pulse, 4'b0001);
      pkt_afc(4'b0001, 2'b11, 4'd8);
      chk("afc11_dup", error_pulse, 0);
      pkt_afc(4'b0001, 2'b11, 4'd9);
      chk("afc11_inc", error_pulse, 0);
      repeat (2) @(negedge clk);
      chk("dup_count", error_count, 32'h0000_0102);
      chk("dup_total", total_errors, 3);

      // filtered and malformed packets on ch0 (last_cc = 9)
      send_raw(4'b0001, 13'h101, 2'b01, 4'd0, 1'b0, 8'h47);
      send_raw(4'b0001, 13'h101, 2'b01, 4'd13, 1'b0, 8'h47);
      chk("pid_filter", error_pulse, 0);
      send_raw(4'b0001, 13'h100, 2'b01, 4'd3, 1'b0, 8'h46);
      chk("bad_sync", error_pulse, 0);
      send_raw(4'b0001, 13'h100, 2'b01, 4'd3, 1'b1, 8'h47);
      chk("tei", error_pulse, 0);
      send_raw(4'b0001, 13'h100, 2'b00, 4'd3, 1'b0, 8'h47);
      chk("afc00", error_pulse, 0);
      pkt(4'b0001, 4'd10);
      chk("after_ignored", error_pulse, 0);

      // sync in mid-header restarts capture
      valid = 4'b0001;
      sync  = 4'b0001;
      data  = {4{8'h47}};
      @(negedge clk);
      sync  = 4'b0000;
      data  = {4{8'h01}};
      @(negedge clk);
      pkt(4'b0001, 4'd14);
      chk("midhdr_err", error_pulse, 4'b0001);

      // saturation on ch2
      pkt(4'b0100, 4'd0);
      for (int k = 1; k <= 300; k++) begin
         pkt(4'b0100, 4'((2 * k) % 16));
         if (error_pulse[2]) npulse++;
      end
      chk("sat_pulses", npulse, 300);
      repeat (2) @(negedge clk);
      chk("sat_count", error_count, 32'h00FF_0103);
      chk("sat_total", total_errors, 259);

      // clear coincident with a ch1 error (ch1 last_cc = 10)
      pkt(4'b0010, 4'd0);
      chk("clr_pulse", error_pulse, 4'b0010);
      en_reset_counter = 1'b1;
      @(negedge clk);
      en_reset_counter = 1'b0;
      chk("clr_count", error_count, 0);
      @(negedge clk);
      chk("clr_total", total_errors, 0);

      // all channels erroring together
      pkt(4'b1000, 4'd0);
      chk("ch3_lock", error_pulse, 0);
      pkt(4'b1111, 4'd5);
      chk("all_pulse", error_pulse, 4'b1111);
      @(negedge clk);
      chk("all_count", error_count, 32'h0101_0101);
      @(negedge clk);
      chk("all_total", total_errors, 4);

      // pid_filter change on ch1 forces relock
      pid_filter[13 +: 13] = 13'h200;
      repeat (2) @(negedge clk);
      send_raw(4'b0010, 13'h200, 2'b01, 4'd0, 1'b0, 8'h47);
      chk("pid_relock", error_pulse, 0);
      send_raw(4'b0010, 13'h200, 2'b01, 4'd7, 1'b0, 8'h47);
      chk("pid_after", error_pulse, 4'b0010);

      // async reset in mid-header
      valid = 4'b0001;
      sync  = 4'b0001;
      data  = {4{8'h47}};
      @(negedge clk);
      sync  = 4'b0000;
      data  = {4{8'h01}};
      @(negedge clk);
      data  = {4{8'h00}};
      #2 reset = 1'b1;
      #1;
      chk("arst_count", error_count, 0);
      chk("arst_pulse", error_pulse, 0);
      chk("arst_total", total_errors, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      data  = {4{8'h13}};
      @(negedge clk);
      valid = '0;
      @(negedge clk);
      chk("arst_parked", error_pulse, 0);
      pkt(4'b0001, 4'd9);
      chk("arst_lock", error_pulse, 0);
      pkt(4'b0001, 4'd3);
      chk("arst_err", error_pulse, 4'b0001);
      @(negedge clk);
      chk("arst_count1", error_count, 32'h0000_0001);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
